alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the custom-ISA datapath. It generalises the 8-bit single-cycle ALU to a configurable width and adds subtract, shift-left and unsigned multiply. Results and flags are registered behind a Start/Done handshake, so the control FSM can issue single-cycle ops every cycle or wait on the multi-cycle multiply.

---
 rtl/alu_mc_if.sv | 26 ++
 rtl/alu_mc.sv | 120 ++++++++++++
 tb/tb_alu_mc.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Start/Done request bus of the multi-cycle ALU: operands and opcode in, registered result and flags out.
interface alu_mc_if #(parameter int W = 8);
    logic         Start;
    logic [2:0]   OP;
    logic [W-1:0] InputA;
    logic [W-1:0] InputB;
    logic         SC_in;
    logic [W-1:0] Out;
    logic [W-1:0] OutHi;
    logic         SC_out;
    logic         Zero;
    logic         Even;
    logic         Equal;
    logic         Busy;
    logic         Done;

    modport master (
        output Start, OP, InputA, InputB, SC_in,
        input  Out, OutHi, SC_out, Zero, Even, Equal, Busy, Done
    );

    modport slave (
        input  Start, OP, InputA, InputB, SC_in,
        output Out, OutHi, SC_out, Zero, Even, Equal, Busy, Done
    );
endinterface

// File: rtl/alu_mc.sv
// Parametrised ALU: single-cycle ops register on the accepting edge; MUL runs W shift-add iterations.
module alu_mc #(
    parameter int W = 8
) (
    input  logic   Clk,
    input  logic   Reset,
    alu_mc_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_SRL   = 3'b011;
    localparam logic [2:0] OP_SLL   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   mplier;

    logic [W-1:0]   out_q;
    logic [W-1:0]   hi_q;
    logic           sc_q;
    logic           zero_q;
    logic           even_q;
    logic           equal_q;

    logic           accept;
    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [W-1:0]   res;
    logic           res_c;

    always_comb begin
        accept = bus.Start && (state != S_MUL);
        sum    = {1'b0, bus.InputA} + {1'b0, bus.InputB} + (W+1)'(bus.SC_in);
        // The extra top bit of the (W+1)-bit difference is the borrow.
        diff   = {1'b0, bus.InputA} - {1'b0, bus.InputB} - (W+1)'(bus.SC_in);
        res    = '0;
        res_c  = 1'b0;
        case (bus.OP)
            OP_ADD:   begin res = sum[W-1:0];  res_c = sum[W]; end
            OP_AND:   res = bus.InputA & bus.InputB;
            OP_XOR:   res = bus.InputA ^ bus.InputB;
            OP_SRL:   begin res = {bus.SC_in, bus.InputA[W-1:1]}; res_c = bus.InputA[0]; end
            OP_SLL:   begin res = {bus.InputA[W-2:0], bus.SC_in}; res_c = bus.InputA[W-1]; end
            OP_SUB:   begin res = diff[W-1:0]; res_c = diff[W]; end
            OP_PASSB: res = bus.InputB;
            default:  res = '0;
        endcase
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            out_q   <= '0;
            hi_q    <= '0;
            sc_q    <= 1'b0;
            zero_q  <= 1'b1;
            even_q  <= 1'b1;
            equal_q <= 1'b0;
        end else if (accept) begin
            equal_q <= (bus.InputA == bus.InputB);
            if (bus.OP == OP_MUL) begin
                state  <= S_MUL;
                cnt    <= CW'(W);
                acc    <= '0;
                mcand  <= {{W{1'b0}}, bus.InputA};
                mplier <= bus.InputB;
            end else begin
                state  <= S_DONE;
                out_q  <= res;
                hi_q   <= '0;
                sc_q   <= res_c;
                zero_q <= (res == '0);
                even_q <= ~res[0];
            end
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            // Last iteration publishes the product straight from the adder output.
            if (cnt == CW'(1)) begin
                state  <= S_DONE;
                out_q  <= acc_next[W-1:0];
                hi_q   <= acc_next[2*W-1:W];
                sc_q   <= |acc_next[2*W-1:W];
                zero_q <= (acc_next == '0);
                even_q <= ~acc_next[0];
            end
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end
    end

    assign bus.Out    = out_q;
    assign bus.OutHi  = hi_q;
    assign bus.SC_out = sc_q;
    assign bus.Zero   = zero_q;
    assign bus.Even   = even_q;
    assign bus.Equal  = equal_q;
    assign bus.Busy   = (state == S_MUL);
    assign bus.Done   = (state == S_DONE);
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at W=8: expected results queued at issue, compared on each Done.
module tb_alu_mc;
    typedef struct {
        logic [7:0] out;
        logic [7:0] hi;
        logic       sc;
        logic       zero;
        logic       even;
        logic       equal;
    } exp_t;

    logic Clk;
    logic Reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    exp_t got_e;

    alu_mc_if #(.W(8)) bus ();
    alu_mc #(.W(8)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic c);
        exp_t e;
        int   x;
        e.out = 8'h00;
        e.hi  = 8'h00;
        e.sc  = 1'b0;
        case (op)
            3'd0: begin x = int'(a) + int'(b) + int'(c); e.out = x[7:0]; e.sc = (x > 255); end
            3'd1: e.out = a & b;
            3'd2: e.out = a ^ b;
            3'd3: begin e.out = {c, a[7:1]}; e.sc = a[0]; end
            3'd4: begin e.out = {a[6:0], c}; e.sc = a[7]; end
            3'd5: begin x = int'(a) - int'(b) - int'(c); e.out = x[7:0]; e.sc = (x < 0); end
            3'd6: begin x = int'(a) * int'(b); e.out = x[7:0]; e.hi = x[15:8]; e.sc = (x > 255); end
            default: e.out = b;
        endcase
        e.zero  = (e.out == 8'h00) && (e.hi == 8'h00);
        e.even  = ~e.out[0];
        e.equal = (a == b);
        return e;
    endfunction

    always @(negedge Clk) begin
        if (bus.Done) begin
            check("done_while_busy", 32'(bus.Busy), 32'd0);
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                got_e = sb.pop_front();
                check("out",    32'(bus.Out),    32'(got_e.out));
                check("outhi",  32'(bus.OutHi),  32'(got_e.hi));
                check("sc_out", 32'(bus.SC_out), 32'(got_e.sc));
                check("zero",   32'(bus.Zero),   32'(got_e.zero));
                check("even",   32'(bus.Even),   32'(got_e.even));
                check("equal",  32'(bus.Equal),  32'(got_e.equal));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input bit hold, input bit push);
        bus.Start  = 1'b1;
        bus.OP     = op;
        bus.InputA = a;
        bus.InputB = b;
        bus.SC_in  = c;
        if (push) sb.push_back(model(op, a, b, c));
        @(posedge Clk);
        #1;
        if (!hold) bus.Start = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge Clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge Clk);
        #1;
    endtask

    task automatic run_one(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic c);
        issue(op, a, b, c, 1'b0, 1'b1);
        wait_drain(30);
    endtask

    initial begin
        int busy_n;
        int done_at;
        bit saw_done;
        logic [2:0] rop;
        n_tests    = 0;
        n_fail     = 0;
        Reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.OP     = 3'd0;
        bus.InputA = 8'h00;
        bus.InputB = 8'h00;
        bus.SC_in  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_out",   32'(bus.Out),    32'h00);
        check("rst_outhi", 32'(bus.OutHi),  32'h00);
        check("rst_sc",    32'(bus.SC_out), 32'd0);
        check("rst_zero",  32'(bus.Zero),   32'd1);
        check("rst_even",  32'(bus.Even),   32'd1);
        check("rst_equal", 32'(bus.Equal),  32'd0);
        check("rst_busy",  32'(bus.Busy),   32'd0);
        check("rst_done",  32'(bus.Done),   32'd0);
        @(posedge Clk);
        #1;

        // ADD latency: Done in N+1 only
        issue(3'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        @(negedge Clk);
        check("add_done_n1", 32'(bus.Done), 32'd1);
        @(negedge Clk);
        check("add_done_n2", 32'(bus.Done), 32'd0);
        @(posedge Clk);
        #1;

        run_one(3'd0, 8'hFF, 8'h01, 1'b0);
        run_one(3'd5, 8'h05, 8'h05, 1'b0);
        run_one(3'd5, 8'h04, 8'h05, 1'b0);
        run_one(3'd3, 8'h04, 8'h00, 1'b1);
        run_one(3'd4, 8'h81, 8'h00, 1'b0);
        run_one(3'd7, 8'h3C, 8'hA5, 1'b1);
        run_one(3'd5, 8'h00, 8'hFF, 1'b1);
        run_one(3'd0, 8'hFF, 8'hFF, 1'b1);

        // MUL timing: Busy for exactly W cycles, Done at N+W+1
        issue(3'd6, 8'h0F, 8'h11, 1'b0, 1'b0, 1'b1);
        busy_n  = 0;
        done_at = 0;
        for (int k = 1; k <= 20 && done_at == 0; k++) begin
            @(negedge Clk);
            if (bus.Busy) busy_n++;
            if (bus.Done) done_at = k;
        end
        check("mul_busy_cycles", 32'(busy_n), 32'd8);
        check("mul_done_cycle", 32'(done_at), 32'd9);
        @(posedge Clk);
        #1;
        run_one(3'd6, 8'hFF, 8'hFF, 1'b0);

        // Start held high: three ops on consecutive edges
        bus.Start = 1'b1;
        issue(3'd0, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
        bus.OP = 3'd1; bus.InputA = 8'h04; bus.InputB = 8'h01; bus.SC_in = 1'b0;
        sb.push_back(model(3'd1, 8'h04, 8'h01, 1'b0));
        @(negedge Clk);
        check("b2b_done1", 32'(bus.Done), 32'd1);
        @(posedge Clk);
        #1;
        bus.OP = 3'd2; bus.InputA = 8'h05; bus.InputB = 8'h05;
        sb.push_back(model(3'd2, 8'h05, 8'h05, 1'b0));
        @(negedge Clk);
        check("b2b_done2", 32'(bus.Done), 32'd1);
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        @(negedge Clk);
        check("b2b_done3", 32'(bus.Done), 32'd1);
        @(negedge Clk);
        check("b2b_done_end", 32'(bus.Done), 32'd0);
        @(posedge Clk);
        #1;

        // Random single-cycle burst with Start held
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 6));
            if (rop == 3'd6) rop = 3'd7;
            issue(rop, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end
        bus.Start = 1'b0;
        wait_drain(10);
        for (int i = 0; i < 5; i++)
            run_one(3'd6, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);

        // Ignored Start during MUL, then reset abort
        issue(3'd6, 8'h0F, 8'h11, 1'b0, 1'b0, 1'b1);
        @(posedge Clk);
        #1;
        issue(3'd2, 8'h0F, 8'h0E, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        sb.delete();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("abort_busy",  32'(bus.Busy),  32'd0);
        check("abort_out",   32'(bus.Out),   32'h00);
        check("abort_outhi", 32'(bus.OutHi), 32'h00);
        check("abort_zero",  32'(bus.Zero),  32'd1);
        saw_done = (bus.Done === 1'b1);
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            if (bus.Done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);

        @(posedge Clk);
        #1;
        run_one(3'd0, 8'h10, 8'h20, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
